// File: rtl/branch_comp_iter.sv
`default_nettype none
// ============================================================================
//  Module   : branch_comp_iter
//  Purpose  : Iterative RV32I branch comparator. Compares DIGIT bits per cycle,
//             most-significant chunk first, and returns BrEq / BrLT / taken /
//             illegal over a valid/ready result handshake.
//  Options  : BRANCH_COMP_EARLY_EXIT_EN - leave the compare loop on the first
//             differing chunk instead of always walking all chunks.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_comp_iter #(
  parameter int XLEN  = 32,
  parameter int DIGIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] dataA,
  input  logic [XLEN-1:0] dataB,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            BrEq,
  output logic            BrLT,
  output logic            taken,
  output logic            illegal
);

  localparam int c_numChunks = XLEN / DIGIT;
  localparam int c_idxW      = (c_numChunks > 1) ? $clog2(c_numChunks) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } stateType;

  stateType            r_state;
  stateType            w_stateNext;

  logic [XLEN-1:0]     r_a;
  logic [XLEN-1:0]     r_b;
  logic [2:0]          r_funct3;
  logic [c_idxW-1:0]   r_idx;
  logic                r_lt;
  logic                r_gt;

  logic [DIGIT-1:0]    w_chunkA;
  logic [DIGIT-1:0]    w_chunkB;
  logic                w_ltNext;
  logic                w_gtNext;
  logic                w_lastChunk;
  logic                w_eqNext;
  logic                w_takenNext;
  logic                w_illegalNext;
  logic                w_signedIn;

  // Current chunk of each latched operand
  assign w_chunkA = r_a[int'(r_idx) * DIGIT +: DIGIT];
  assign w_chunkB = r_b[int'(r_idx) * DIGIT +: DIGIT];

  // Once a difference has been seen the flags are frozen
  assign w_ltNext = r_lt | (~r_gt & (w_chunkA < w_chunkB));
  assign w_gtNext = r_gt | (~r_lt & (w_chunkA > w_chunkB));
  assign w_eqNext = ~(w_ltNext | w_gtNext);

  // Only BLTU/BGEU are unsigned; illegal codes also use the signed rule
  assign w_signedIn = (funct3[2:1] != 2'b11);

`ifdef BRANCH_COMP_EARLY_EXIT_EN
  assign w_lastChunk = (r_idx == '0) || w_ltNext || w_gtNext;
`else
  assign w_lastChunk = (r_idx == '0);
`endif

  // Branch decision from the final flags and the latched funct3
  always_comb begin
    w_takenNext   = 1'b0;
    w_illegalNext = 1'b0;
    case (r_funct3)
      3'b000:          w_takenNext = w_eqNext;
      3'b001:          w_takenNext = ~w_eqNext;
      3'b100, 3'b110:  w_takenNext = w_ltNext;
      3'b101, 3'b111:  w_takenNext = ~w_ltNext;
      default:         w_illegalNext = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_stateNext;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    w_stateNext = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_stateNext = S_CMP;
      end
      S_CMP: begin
        if (w_lastChunk) w_stateNext = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Operand latch, chunk walk and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_funct3 <= '0;
      r_idx    <= '0;
      r_lt     <= 1'b0;
      r_gt     <= 1'b0;
      BrEq     <= 1'b0;
      BrLT     <= 1'b0;
      taken    <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            // Flipping the sign bit of both operands maps signed order onto unsigned order
            r_a      <= {dataA[XLEN-1] ^ w_signedIn, dataA[XLEN-2:0]};
            r_b      <= {dataB[XLEN-1] ^ w_signedIn, dataB[XLEN-2:0]};
            r_funct3 <= funct3;
            r_idx    <= c_idxW'(c_numChunks - 1);
            r_lt     <= 1'b0;
            r_gt     <= 1'b0;
          end
        end
        S_CMP: begin
          r_lt <= w_ltNext;
          r_gt <= w_gtNext;
          if (w_lastChunk) begin
            BrEq    <= w_eqNext;
            BrLT    <= w_ltNext;
            taken   <= w_takenNext;
            illegal <= w_illegalNext;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/branch_comp_iter.md
# branch_comp_iter

Parametrised, iterative branch comparator for the RV32I decoder/execute path. It accepts two XLEN-bit register operands and a branch funct3 over a valid/ready handshake, then compares DIGIT bits per cycle, most-significant chunk first. It returns BrEq, BrLT, the resolved branch decision and an illegal-funct3 flag over a second valid/ready handshake. It replaces the single-cycle comparator wherever area matters more than branch latency.

## Interface
- XLEN, 32, operand width; must be a multiple of DIGIT.
- DIGIT, 4, bits compared per cycle; N = XLEN/DIGIT chunks.
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- funct3  input  3  branch funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- dataA  input  XLEN  rs1 value.
- dataB  input  XLEN  rs2 value.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed when out_valid && out_ready.
- BrEq  output  1  dataA == dataB.
- BrLT  output  1  dataA < dataB; signed unless funct3[2:1] == 2'b11.
- taken  output  1  branch decision for funct3.
- illegal  output  1  funct3 is 010 or 011.

## Operation
- States: IDLE, CMP, DONE. in_ready = (state == IDLE); out_valid = (state == DONE).
- IDLE, on accept:
  - Latch funct3.
  - Latch the operands. For signed compares (funct3[2:1] != 2'b11), invert bit XLEN-1 of both operands at latch time so that an unsigned compare gives the signed result.
  - Set chunk index idx = N-1, clear lt/gt flags, go to CMP.
- CMP, each cycle: compare chunk idx of A against chunk idx of B.
  - A chunk < B chunk: set lt.
  - A chunk > B chunk: set gt.
  - Once lt or gt is set, later chunks do not change the flags.
  - Leave CMP when idx == 0, or earlier per Configuration. Otherwise idx decrements.
- On entering DONE, register the results:
  - BrEq = !(lt || gt); BrLT = lt.
  - taken: BEQ → BrEq; BNE → !BrEq; BLT/BLTU → BrLT; BGE/BGEU → !BrLT; 010/011 → 0 with illegal = 1.
- DONE holds all result outputs stable until out_valid && out_ready, then goes to IDLE.
- BrEq/BrLT are still computed for illegal funct3, using the signed rule.

## Timing
- Reset (rst_n low at a rising edge):
  - state = IDLE, so in_ready = 1.
  - out_valid, BrEq, BrLT, taken and illegal all reset to 0.
  - idx and the lt/gt flags are cleared.
- Reset mid-CMP or mid-DONE aborts the operation. No out_valid is produced for it.
- Let k be the number of CMP cycles. out_valid rises on the k-th rising edge after the accept edge. Request-to-result latency is k+1 cycles counted from the accept cycle.
- No overlap between operations: in_ready is 0 from the accept edge until the edge that completes the out handshake. The earliest next accept is the cycle after out_valid && out_ready.
- in_valid, funct3 and the operands are ignored outside IDLE.
- Operands may change after the accept edge; the latched copies are used.

## Configuration
- BRANCH_COMP_EARLY_EXIT_EN defined:
  - CMP exits on the first chunk where lt or gt becomes set, or at idx == 0.
  - k = number of chunks from the MSB down to and including the first differing chunk, with 1 ≤ k ≤ N.
  - Equal operands take k = N.
- BRANCH_COMP_EARLY_EXIT_EN undefined: CMP always runs all N chunks, so k = N and latency is fixed at N+1 cycles.
- Functional results are identical in both configurations.

## Test plan
All scenarios use XLEN=32, DIGIT=4, N=8.
- BEQ, A = B = 0x12345678 → BrEq=1, BrLT=0, taken=1, illegal=0; out_valid 8 edges after accept in both configs.
- BLT, A = 0xFFFFFFFF, B = 0x00000001 → BrLT=1, BrEq=0, taken=1; k=1 with EARLY_EXIT, k=8 without.
- BLTU, same operands → BrLT=0, BrEq=0, taken=0; k=1 with EARLY_EXIT, k=8 without.
- BNE, A = 0x80000000, B = 0x80000001 → BrEq=0, taken=1; k=8 in both configs. BGE with the same operands → BrLT=1, taken=0.
- BGEU, A = 0x00000010, B = 0x00000010, out_ready held low 3 cycles after out_valid rises:
  - Outputs hold BrEq=1, taken=1; in_ready stays 0; a new in_valid is ignored.
  - After out_ready pulses, in_ready=1 on the next cycle.
- funct3 = 3'b010 → illegal=1, taken=0. A separate op has rst_n driven low for one edge during CMP: out_valid never rises, in_ready=1 after that edge, and all outputs are 0.
